result_axis_tx: RTL and testbench
=================================

# result_axis_tx

Output-side AXI-Stream transmitter of the convolution accelerator. It captures one full output frame of O_DIM x O_DIM fp16 results from the convolution core through a simple write port. On a frame-done pulse it streams the frame in row-major order on the accelerator's output AXIS channel, honouring back-pressure and marking the final word with last. It is the counterpart of the image and kernel AXIS receivers and drives the out_data/out_last/out_valid/out_ready port of the top-level wrapper.

## Interface
- K_DIM, default 3: kernel dimension.
- I_DIM, default 3: image cache dimension.
- M_BITS, default 16: word width (fp16).
- O_DIM, derived: K_DIM + I_DIM - 1 (5 at defaults).
- O_SIZE, derived: O_DIM squared (25).
- A_BITS, derived: nbits(O_SIZE) (5).

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  result write strobe from the core.
- wr_addr  in  A_BITS  row-major index, row * O_DIM + col.
- wr_data  in  M_BITS  fp16 result.
- frame_done  in  1  one-cycle pulse: frame complete, start streaming.
- wr_ready  out  1  high in IDLE; writes are accepted only when high.
- wr_drop  out  1  sticky flag: a write or frame_done arrived while not in IDLE.
- out_data  out  M_BITS  AXIS data.
- out_last  out  1  AXIS last; high only with word O_SIZE-1.
- out_valid  out  1  AXIS valid.
- out_ready  in  1  AXIS ready from the downstream sink.

## Operation
- Storage: O_SIZE x M_BITS register array. Contents are not cleared by reset and persist between frames.
- FSM states:
  - IDLE: wr_ready=1; writes with wr_en=1 and wr_addr < O_SIZE are committed at the clock edge; out-of-range addresses are silently ignored. frame_done=1 goes to SEND.
  - SEND: wr_ready=0; streams words 0..O_SIZE-1. Moves to IDLE after the handshake (out_valid & out_ready) on the word with out_last=1.
- Read pointer rd_ptr, A_BITS wide:
  - Cleared to 0 on the transition into SEND.
  - Increments on every handshake.
  - Never wraps; terminal value is O_SIZE-1.
- Output stage is registered. out_data/out_last are updated only on SEND entry or on a handshake, so they stay stable while out_valid=1 and out_ready=0 (AXIS rule).
- Bypass: if wr_en and frame_done occur in the same IDLE cycle, the write is committed first. If that write targets address 0, the first streamed word is wr_data.
- Events that set wr_drop:
  - wr_en or frame_done in SEND: ignored, wr_drop set.
  - frame_done while already in SEND: ignored, wr_drop set.
  - wr_drop clears only on rst.
- Data is passed through untouched; no fp16 arithmetic.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, wr_ready=1, wr_drop=0, state IDLE, rd_ptr=0.
- Reset mid-stream: at the next edge out_valid=0 and state is IDLE. The partial frame is abandoned and is not resumed.
- Latency: frame_done sampled at edge t gives out_valid=1 with word 0 after edge t (cycle t+1).
- Throughput: with out_ready held high, one word per cycle. A 25-word frame occupies cycles t+1..t+25.
- After the last handshake at edge e: out_valid=0, out_last=0, wr_ready=1 after edge e.
- Earliest next frame_done: the cycle after e.
- out_valid never drops during SEND until the last handshake. out_valid does not depend combinationally on out_ready.

## Structure
- Shared package acc_pkg holds:
  - the nbits() and sq() helper functions;
  - derived constants O_DIM, O_SIZE, A_BITS;
  - the enum typedef tx_state_t {IDLE, SEND};
  - typedef fp16_t = logic [15:0].
- One sub-module: axis_out_reg, the output register stage. It holds data, last and valid, loads on SEND entry or a handshake, and is reusable by other AXIS transmitters in the accelerator.

## Test plan
- Basic frame: write addr k with 16'h3C00 + k for k = 0..24, pulse frame_done, out_ready=1 -> 25 consecutive beats of 16'h3C00..16'h3C18; out_last only on 16'h3C18; out_valid low the cycle after.
- Back-pressure: same frame with out_ready toggling 1,0,0,1 -> out_data/out_last held stable while stalled; all 25 words in order; no duplicates or gaps.
- Simultaneous write and done: wr_en with addr 0, data 16'h4500, in the same cycle as frame_done -> first beat is 16'h4500.
- Illegal traffic: wr_en with addr 3 and a second frame_done mid-stream -> streamed word 3 unchanged, stream length still 25, wr_drop=1 until rst.
- Out-of-range write: wr_addr=25 in IDLE -> no array change, wr_drop stays 0.
- Reset mid-stream: rst asserted at beat 10 -> out_valid=0 next cycle, wr_ready=1. A fresh frame_done restarts the stream from word 0 with the retained contents.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared constants, helpers and types for the convolution accelerator datapath.
package acc_pkg;

    // Number of bits needed to represent the value n (nbits(25) = 5).
    function automatic int unsigned nbits(input int unsigned n);
        int unsigned b;
        int unsigned v;
        b = 0;
        v = n;
        while (v > 0) begin
            b = b + 1;
            v = v >> 1;
        end
        return (b == 0) ? 1 : b;
    endfunction

    function automatic int unsigned sq(input int unsigned n);
        return n * n;
    endfunction

    localparam int unsigned DEF_K_DIM = 3;
    localparam int unsigned DEF_I_DIM = 3;

    // Derived sizes at the default kernel/image dimensions.
    localparam int unsigned O_DIM  = DEF_K_DIM + DEF_I_DIM - 1;
    localparam int unsigned O_SIZE = sq(O_DIM);
    localparam int unsigned A_BITS = nbits(O_SIZE);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    typedef logic [15:0] fp16_t;

endpackage

// File: rtl/axis_out_reg.sv
// Registered AXIS output stage: data/last/valid change only when load_i is high,
// so the beat stays stable while the sink stalls.
module axis_out_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         valid_i,
    output logic [W-1:0] data_o,
    output logic         last_o,
    output logic         valid_o
);

    // Output register, loaded on stream start or on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o  <= '0;
            last_o  <= 1'b0;
            valid_o <= 1'b0;
        end else if (load_i) begin
            data_o  <= data_i;
            last_o  <= last_i;
            valid_o <= valid_i;
        end
    end

endmodule

// File: rtl/result_axis_tx.sv
// Captures one O_DIM x O_DIM fp16 result frame, then streams it row-major on AXIS.
module result_axis_tx
    import acc_pkg::*;
#(
    parameter int unsigned K_DIM  = DEF_K_DIM,
    parameter int unsigned I_DIM  = DEF_I_DIM,
    parameter int unsigned M_BITS = 16,
    parameter int unsigned O_DIM  = K_DIM + I_DIM - 1,
    parameter int unsigned O_SIZE = sq(O_DIM),
    parameter int unsigned A_BITS = nbits(O_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [A_BITS-1:0] wr_addr,
    input  logic [M_BITS-1:0] wr_data,
    input  logic              frame_done,
    output logic              wr_ready,
    output logic              wr_drop,
    output logic [M_BITS-1:0] out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [A_BITS-1:0] LastIdx = A_BITS'(O_SIZE - 1);

    tx_state_t         state_q, state_d;
    logic [A_BITS-1:0] rd_ptr_q, rd_ptr_d, rd_nxt;
    logic              wr_drop_q, wr_drop_d;
    logic [M_BITS-1:0] mem_q [O_SIZE];

    logic              wr_hit;
    logic              hs;
    logic              ld;
    logic [M_BITS-1:0] ld_data;
    logic              ld_last;
    logic              ld_valid;

    assign wr_hit   = (state_q == IDLE) && wr_en && (wr_addr <= LastIdx);
    assign hs       = out_valid && out_ready;
    assign rd_nxt   = rd_ptr_q + A_BITS'(1);
    assign wr_ready = (state_q == IDLE);
    assign wr_drop  = wr_drop_q;

    // Next-state, read pointer and output-stage load selection.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_drop_d = wr_drop_q;
        ld        = 1'b0;
        ld_data   = out_data;
        ld_last   = 1'b0;
        ld_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_done) begin
                    state_d  = SEND;
                    rd_ptr_d = '0;
                    ld       = 1'b1;
                    // A same-cycle write to word 0 bypasses the array.
                    ld_data  = (wr_hit && (wr_addr == '0)) ? wr_data : mem_q[0];
                    ld_last  = (O_SIZE == 1);
                    ld_valid = 1'b1;
                end
            end
            SEND: begin
                if (wr_en || frame_done) begin
                    wr_drop_d = 1'b1;
                end
                if (hs) begin
                    ld = 1'b1;
                    if (out_last) begin
                        state_d  = IDLE;
                        ld_data  = out_data;
                        ld_last  = 1'b0;
                        ld_valid = 1'b0;
                    end else begin
                        rd_ptr_d = rd_nxt;
                        ld_data  = mem_q[rd_nxt];
                        ld_last  = (rd_nxt == LastIdx);
                        ld_valid = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Frame storage: not reset, contents persist between frames.
    always_ff @(posedge clk) begin
        if (!rst && wr_hit) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    axis_out_reg #(
        .W(M_BITS)
    ) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (ld),
        .data_i (ld_data),
        .last_i (ld_last),
        .valid_i(ld_valid),
        .data_o (out_data),
        .last_o (out_last),
        .valid_o(out_valid)
    );

endmodule

// File: tb/tb_result_axis_tx.sv
// Scoreboard bench for result_axis_tx: driver pushes expected beats, monitor pops on handshakes.
module tb_result_axis_tx;

    localparam int N = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_done;
    logic        wr_ready;
    logic        wr_drop;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [N];
    logic [16:0] exp_q [$];
    int          beats;
    int          rdy_mode;
    int          ph;

    logic        stall_p;
    logic [15:0] stall_d;
    logic        stall_l;

    always #5 clk = ~clk;

    result_axis_tx dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_done(frame_done),
        .wr_ready  (wr_ready),
        .wr_drop   (wr_drop),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sink ready: always high, 1,0,0,1 pattern, or random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compare every accepted beat and check stability while stalled.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                chk("stall valid", 32'(out_valid), 32'd1);
                chk("stall data", 32'(out_data), 32'(stall_d));
                chk("stall last", 32'(out_last), 32'(stall_l));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra beat", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat data", 32'(out_data), 32'(e[15:0]));
                    chk("beat last", 32'(out_last), 32'(e[16]));
                    beats++;
                end
            end else if (out_valid && exp_q.size() == 0) begin
                chk("spurious valid", 32'(out_valid), 32'd0);
            end
            stall_p = out_valid && !out_ready;
            stall_d = out_data;
            stall_l = out_last;
        end
    end

    task automatic wr(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a[4:0];
        wr_data = d;
        if (a < N) model_mem[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Pulse frame_done (caller may hold wr_en in the same cycle) and queue the frame.
    task automatic start_frame();
        frame_done = 1'b1;
        beats = 0;
        for (int k = 0; k < N; k++) exp_q.push_back({(k == N - 1), model_mem[k]});
        tick();
        frame_done = 1'b0;
        wr_en = 1'b0;
        chk("latency valid", 32'(out_valid), 32'd1);
        chk("wr_ready in send", 32'(wr_ready), 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_ready !== 1'b1) && n < 500) begin
            tick();
            n++;
        end
        chk({name, " drained"}, 32'(n < 500), 32'd1);
        chk({name, " valid after last"}, 32'(out_valid), 32'd0);
        chk({name, " last after last"}, 32'(out_last), 32'd0);
        chk({name, " beats"}, 32'(beats), 32'(N));
        if (n >= 500) exp_q.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        frame_done = 1'b0;
        out_ready = 1'b1;
        rdy_mode = 0;
        ph = 0;
        beats = 0;
        stall_p = 1'b0;
        repeat (2) tick();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_last", 32'(out_last), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst wr_ready", 32'(wr_ready), 32'd1);
        chk("rst wr_drop", 32'(wr_drop), 32'd0);
        rst = 1'b0;
        tick();

        // Basic frame.
        for (int k = 0; k < N; k++) wr(k, 16'(16'h3C00 + k));
        start_frame();
        wait_idle("basic");

        // Back-pressure with ready pattern 1,0,0,1; starts the cycle after the last beat.
        ph = 0;
        rdy_mode = 1;
        start_frame();
        wait_idle("backpressure");
        rdy_mode = 0;

        // Write to word 0 in the same cycle as frame_done.
        wr_en = 1'b1;
        wr_addr = 5'd0;
        wr_data = 16'h4500;
        model_mem[0] = 16'h4500;
        start_frame();
        wait_idle("bypass");

        // Out-of-range writes are ignored without flagging a drop.
        wr(25, 16'hBEEF);
        wr(31, 16'hBEEF);
        chk("oor wr_drop", 32'(wr_drop), 32'd0);
        start_frame();
        wait_idle("oor");

        // Random partial rewrites with random back-pressure.
        rdy_mode = 2;
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(1, 30);
            for (int i = 0; i < n; i++) wr($urandom_range(0, N - 1), 16'($urandom));
            repeat ($urandom_range(0, 3)) tick();
            start_frame();
            wait_idle("random");
            chk("random wr_drop", 32'(wr_drop), 32'd0);
        end
        rdy_mode = 0;

        // Illegal traffic mid-stream: write and second frame_done are dropped.
        start_frame();
        repeat (3) tick();
        wr_en = 1'b1;
        wr_addr = 5'd3;
        wr_data = 16'hDEAD;
        frame_done = 1'b1;
        tick();
        wr_en = 1'b0;
        frame_done = 1'b0;
        chk("illegal wr_drop set", 32'(wr_drop), 32'd1);
        wait_idle("illegal");
        repeat (2) tick();
        chk("illegal wr_drop sticky", 32'(wr_drop), 32'd1);

        // Reset at beat 10, then a fresh frame from retained contents.
        start_frame();
        n = 0;
        while (beats < 10 && n < 200) begin
            tick();
            n++;
        end
        chk("reach beat 10", 32'(n < 200), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_last", 32'(out_last), 32'd0);
        chk("midrst wr_ready", 32'(wr_ready), 32'd1);
        chk("midrst wr_drop", 32'(wr_drop), 32'd0);
        tick();
        start_frame();
        wait_idle("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
